// File: rtl/life_sequencer.sv
// rtl/life_sequencer.sv - button-driven run/pause/step/reload sequencer for the Conway cell array
// Optional STALL_DETECT_EN: flag (and leave RUN) when a step leaves the board unchanged.
module life_sequencer #(
  parameter int N               = 8,
  parameter int TICK_PERIOD     = 8388608,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int NUM_PATTERNS    = 4,
  parameter int GEN_W           = 16,
  localparam int PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_load,
  input  logic [N*N-1:0]   cells_q,
  output logic             load_cells,
  output logic             step_game,
  output logic             running,
  output logic [PW-1:0]    pattern_sel,
  output logic [GEN_W-1:0] generation,
  output logic             stalled
);
  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_LOAD, S_PAUSED, S_RUN, S_STEP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pattern_q, pattern_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             running_q;
  logic             stall_hit;

  // Button bit order: [0] run, [1] step, [2] load.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q, filt_q, press_q;
  logic [DW-1:0] db_cnt_q [3];
  logic          run_ev, step_ev, load_ev;

  assign btn_raw = {btn_load, btn_step, btn_run};
  assign run_ev  = press_q[0];
  assign step_ev = press_q[1];
  assign load_ev = press_q[2];

  // The filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q[i] <= '0;
          filt_q[i]   <= sync2_q[i];
          press_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic [PW-1:0] next_pattern(input logic [PW-1:0] p);
    return (p == PW'(NUM_PATTERNS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    gen_d      = gen_q;
    tick_d     = '0;
    load_cells = 1'b0;
    step_game  = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_cells = 1'b1;
        gen_d      = '0;
        state_d    = S_PAUSED;
      end
      S_PAUSED: begin
        if (load_ev) begin
          pattern_d = next_pattern(pattern_q);
          state_d   = S_LOAD;
        end else if (run_ev) begin
          state_d = S_RUN;
        end else if (step_ev) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        step_game = 1'b1;
        gen_d     = gen_q + 1'b1;
        state_d   = S_PAUSED;
      end
      default: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TW'(TICK_PERIOD - 1)) begin
          step_game = 1'b1;
          gen_d     = gen_q + 1'b1;
          tick_d    = '0;
        end
        // The tick strobe above still fires when an event lands on the same cycle.
        if (load_ev) begin
          pattern_d = next_pattern(pattern_q);
          state_d   = S_LOAD;
        end else if (run_ev || stall_hit) begin
          state_d = S_PAUSED;
        end
        if (state_d != S_RUN) tick_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      pattern_q <= '0;
      gen_q     <= '0;
      tick_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      gen_q     <= gen_d;
      tick_q    <= tick_d;
      running_q <= (state_d == S_RUN);
    end
  end

`ifdef STALL_DETECT_EN
  logic [N*N-1:0] snap_q;
  logic           chk_q;
  logic           stalled_q;

  // cells_q reflects the step one cycle after the strobe, so compare then.
  assign stall_hit = chk_q && (cells_q == snap_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q    <= '0;
      chk_q     <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      chk_q <= step_game;
      if (step_game) snap_q <= cells_q;
      if (run_ev || step_ev || load_ev) stalled_q <= 1'b0;
      else if (stall_hit) stalled_q <= 1'b1;
    end
  end

  assign stalled = stalled_q;
`else
  logic unused_cells;
  assign unused_cells = ^cells_q;
  assign stall_hit    = 1'b0;
  assign stalled      = 1'b0;
`endif

  assign running     = running_q;
  assign pattern_sel = pattern_q;
  assign generation  = gen_q;
endmodule
